// File: rtl/counters_pkg.sv
// Shared types and constants for the sequential-counters library.
// Imported by the up/down counter blocks.
package counters_pkg;

  localparam int ST_W          = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_count_core.sv
// Datapath for the down-count timer: current count plus the reload register,
// with load / reload / decrement / hold controls and zero/one detection.
module down_count_core
  import counters_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             is_zero,
  output logic             reload_zero
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;

  // Count and reload register update; load wins over reload, reload over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= ZERO;
      reload_r <= ZERO;
    end else if (load) begin
      count_r  <= load_val;
      reload_r <= load_val;
    end else if (reload) begin
      count_r  <= reload_r;
    end else if (dec) begin
      count_r  <= count_r - ONE;
    end else begin
      count_r  <= count_r;
    end
  end

  assign count       = count_r;
  assign is_one      = (count_r == ONE);
  assign is_zero     = (count_r == ZERO);
  assign reload_zero = (reload_r == ZERO);

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter / interval timer with one-shot and periodic modes,
// pause/resume, and a one-cycle terminal-count pulse.
module down_count_timer
  import counters_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e state_r;
  state_e next_state_s;
  logic   tc_r;
  logic   tc_next_s;
  logic   reload_s;
  logic   dec_s;
  logic   is_one_s;
  logic   is_zero_s;
  logic   reload_zero_s;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .reload      (reload_s),
    .dec         (dec_s),
    .count       (count),
    .is_one      (is_one_s),
    .is_zero     (is_zero_s),
    .reload_zero (reload_zero_s)
  );

  // State and terminal-count pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      tc_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      tc_r    <= tc_next_s;
    end
  end

  // Next-state and datapath control; load beats stop, stop beats start.
  always_comb begin
    next_state_s = state_r;
    tc_next_s    = 1'b0;
    reload_s     = 1'b0;
    dec_s        = 1'b0;
    if (load) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!stop && start) begin
            if (is_zero_s) begin
              next_state_s = DONE;
              tc_next_s    = 1'b1;
            end else begin
              next_state_s = RUN;
            end
          end else begin
            next_state_s = IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            next_state_s = IDLE;
          end else if (!enable) begin
            next_state_s = RUN;
          end else if (is_zero_s) begin
            // Unreachable in normal use; treated as terminal rather than wrapping.
            next_state_s = DONE;
            tc_next_s    = 1'b1;
          end else if (is_one_s) begin
            tc_next_s = 1'b1;
            if (auto_reload) begin
              reload_s     = 1'b1;
              next_state_s = RUN;
            end else begin
              dec_s        = 1'b1;
              next_state_s = DONE;
            end
          end else begin
            dec_s = 1'b1;
          end
        end
        DONE: begin
          if (!stop && start) begin
            if (reload_zero_s) begin
              tc_next_s    = 1'b1;
              next_state_s = DONE;
            end else begin
              reload_s     = 1'b1;
              next_state_s = RUN;
            end
          end else begin
            next_state_s = DONE;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r == RUN);
  assign done = (state_r == DONE);
  assign tc   = tc_r;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed self-checking bench for down_count_timer (WIDTH=4).
module tb_down_count_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic       enable;
  logic       auto_reload;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  down_count_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; load_val = 4'd7; start = 1'b0; stop = 1'b0;
    enable = 1'b1; auto_reload = 1'b0;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({count, busy, tc, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
    end
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy, tc, done} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_start_zero: got count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
    end
    tick();
    vectors++;
    if ({tc, done} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_tc_width: got tc=%b done=%b, want 0 1", tc, done);
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_cnt [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    idle_inputs(); enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    vectors++;
    if ({count, busy, done} !== {4'd5, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL one_shot_load: got count=%0d busy=%b done=%b, want 5 0 0", count, busy, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy, tc} !== {4'd5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL one_shot_start: got count=%0d busy=%b tc=%b, want 5 1 0", count, busy, tc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({count, busy, tc, done} !== {exp_cnt[i], (i != 4), (i == 4), (i == 4)}) begin
        miscompares++;
        $display("FAIL one_shot_step%0d: got count=%0d busy=%b tc=%b done=%b, want %0d %b %b %b",
                 i, count, busy, tc, done, exp_cnt[i], (i != 4), (i == 4), (i == 4));
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({count, busy, tc, done} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL one_shot_hold%0d: got count=%0d busy=%b tc=%b done=%b, want 0 0 0 1", i, count, busy, tc, done);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_cnt [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    idle_inputs(); enable = 1'b1; auto_reload = 1'b1;
    load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy} !== {4'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL auto_start: got count=%0d busy=%b, want 3 1", count, busy);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if ({count, busy, tc, done} !== {exp_cnt[i], 1'b1, (i % 3 == 2), 1'b0}) begin
        miscompares++;
        $display("FAIL auto_step%0d: got count=%0d busy=%b tc=%b done=%b, want %0d 1 %b 0",
                 i, count, busy, tc, done, exp_cnt[i], (i % 3 == 2));
      end
    end
    stop = 1'b1; auto_reload = 1'b0;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_enable_pause();
    logic [3:0] exp_cnt [4] = '{4'd5, 4'd5, 4'd4, 4'd4};
    idle_inputs(); enable = 1'b0; auto_reload = 1'b0;
    load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable = (i % 2 == 0);
      tick();
      vectors++;
      if ({count, busy} !== {exp_cnt[i], 1'b1}) begin
        miscompares++;
        $display("FAIL gate_step%0d: got count=%0d busy=%b, want %0d 1", i, count, busy, exp_cnt[i]);
      end
    end
    stop = 1'b1; enable = 1'b0;
    tick();
    stop = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({count, busy, tc} !== {4'd4, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL pause_hold%0d: got count=%0d busy=%b tc=%b, want 4 0 0", i, count, busy, tc);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy} !== {4'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL resume_start: got count=%0d busy=%b, want 4 1", count, busy);
    end
    tick();
    vectors++;
    if (count !== 4'd3) begin
      miscompares++;
      $display("FAIL resume_dec: got count=%0d, want 3", count);
    end
  endtask

  task automatic test_priority();
    // Running at count=3 from the previous scenario.
    idle_inputs(); enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; stop = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; stop = 1'b0;
    vectors++;
    if ({count, busy, tc, done} !== {4'd9, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_stop: got count=%0d busy=%b tc=%b done=%b, want 9 0 0 0", count, busy, tc, done);
    end
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      vectors++;
      if ({count, tc, done} !== {4'(15 - i), (i == 15), (i == 15)}) begin
        miscompares++;
        $display("FAIL max_step%0d: got count=%0d tc=%b done=%b, want %0d %b %b",
                 i, count, tc, done, 15 - i, (i == 15), (i == 15));
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy, tc, done} !== {4'd15, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL done_restart: got count=%0d busy=%b tc=%b done=%b, want 15 1 0 0", count, busy, tc, done);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_simultaneous();
    idle_inputs(); enable = 1'b1; auto_reload = 1'b0;
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    vectors++;
    if ({count, busy} !== {4'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset_count: got count=%0d busy=%b, want 2 1", count, busy);
    end
    rst = 1'b1; load = 1'b1; load_val = 4'd9; start = 1'b1;
    tick();
    idle_inputs();
    vectors++;
    if ({count, busy, tc, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_load_start: got count=%0d busy=%b tc=%b done=%b, want 0 0 0 0", count, busy, tc, done);
    end
    // Reload register was cleared by reset: two starts both end in DONE with tc.
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy, tc, done} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL done_reload_zero: got count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
    end
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({count, busy, tc, done} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL load_zero_start: got count=%0d busy=%b tc=%b done=%b, want 0 0 1 1", count, busy, tc, done);
    end
    tick();
    vectors++;
    if ({tc, done} !== {1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL load_zero_tc_width: got tc=%b done=%b, want 0 1", tc, done);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; stop = 1'b0;
    enable = 1'b0; auto_reload = 1'b0;
    tick();
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_pause();
    test_priority();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
